// File: rtl/mysystem_cpu_debug_ocimem_ctrl.sv
// Debug-memory controller: services JTAG ocimem strobes against the on-chip
// debug RAM and, when MYSYSTEM_OCIMEM_CPU_PORT_EN is defined, arbitrates a CPU port.
//
// state | meaning
// IDLE  | executes the pending JTAG action, else grants the CPU
// JRD   | JTAG read data in rd_q, delivered to MonDReg this cycle
// CRD   | CPU read data in rd_q, presented with waitrequest low
module mysystem_cpu_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] JRD  = 2'd1;
`ifdef MYSYSTEM_OCIMEM_CPU_PORT_EN
  localparam logic [1:0] CRD  = 2'd2;
`endif

  localparam logic [1:0] ACT_NONE = 2'd0;
  localparam logic [1:0] ACT_A    = 2'd1;
  localparam logic [1:0] ACT_NA   = 2'd2;
  localparam logic [1:0] ACT_B    = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] mon_a;
  logic              pend_valid;
  logic [1:0]        pend_act;
  logic [32:0]       pend_word;   // jdo[35:3]
  logic [31:0]       rd_q;
  logic [31:0]       ram [0:(1<<ADDR_W)-1];

  logic [1:0]        new_act;
  logic              idle;
  logic [1:0]        exec_act;
  logic [8:0]        ex_field;
  logic              ex_rd;
  logic [31:0]       ex_wdata;
  logic              ex_illegal;
  logic [ADDR_W-1:0] ex_addr;
  logic [ADDR_W-1:0] mon_a_inc;
  logic              jtag_busy;
  logic              cpu_grant_rd;
  logic              cpu_grant_wr;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;

  logic              jdo_unused;
  assign jdo_unused = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    new_act = ACT_NONE;
    if (take_action_ocimem_a)
      new_act = ACT_A;
    else if (take_no_action_ocimem_a)
      new_act = ACT_NA;
    else if (take_action_ocimem_b)
      new_act = ACT_B;
  end

  assign idle       = (state == IDLE);
  assign exec_act   = (idle && pend_valid) ? pend_act : ACT_NONE;
  assign ex_field   = pend_word[22:14];
  assign ex_rd      = pend_word[32];
  assign ex_wdata   = pend_word[31:0];
  assign ex_illegal = |(ex_field >> ADDR_W);
  assign ex_addr    = ex_field[ADDR_W-1:0];
  assign mon_a_inc  = mon_a + ADDR_W'(1);
  assign jtag_busy  = pend_valid || (new_act != ACT_NONE);

`ifdef MYSYSTEM_OCIMEM_CPU_PORT_EN
  // A strobe arriving this cycle already outranks the CPU.
  assign cpu_grant_rd    = idle && !jtag_busy && cpu_read && !reset;
  assign cpu_grant_wr    = idle && !jtag_busy && cpu_write && !cpu_read && !reset;
  assign cpu_waitrequest = (cpu_read || cpu_write) && !(cpu_grant_wr || state == CRD);
  assign cpu_readdata    = (state == CRD) ? rd_q : 32'h0;
`else
  logic cpu_unused;
  assign cpu_unused      = ^{cpu_address, cpu_read, cpu_write, cpu_writedata, jtag_busy};
  assign cpu_grant_rd    = 1'b0;
  assign cpu_grant_wr    = 1'b0;
  assign cpu_waitrequest = 1'b0;
  assign cpu_readdata    = 32'h0;
`endif

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = mon_a;
    ram_wdata = ex_wdata;
    case (exec_act)
      ACT_A: begin
        if (!ex_illegal && ex_rd) begin
          ram_re   = 1'b1;
          ram_addr = ex_addr;
        end
      end
      ACT_NA: begin
        ram_re   = 1'b1;
        ram_addr = mon_a_inc;
      end
      ACT_B: begin
        ram_we = 1'b1;
      end
      default: begin
        if (cpu_grant_rd) begin
          ram_re   = 1'b1;
          ram_addr = cpu_address;
        end else if (cpu_grant_wr) begin
          ram_we    = 1'b1;
          ram_addr  = cpu_address;
          ram_wdata = cpu_writedata;
        end
      end
    endcase
  end

  // Contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we)
      ram[ram_addr] <= ram_wdata;
    if (ram_re)
      rd_q <= ram[ram_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mon_a         <= '0;
      pend_valid    <= 1'b0;
      pend_act      <= ACT_NONE;
      pend_word     <= '0;
      MonDReg       <= 32'h0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          case (exec_act)
            ACT_A: begin
              monitor_ready <= 1'b0;
              if (ex_illegal) begin
                monitor_error <= 1'b1;
              end else begin
                mon_a         <= ex_addr;
                monitor_error <= 1'b0;
                if (ex_rd)
                  state <= JRD;
              end
            end
            ACT_NA: begin
              monitor_ready <= 1'b0;
              mon_a         <= mon_a_inc;
              state         <= JRD;
            end
            ACT_B: begin
              mon_a <= mon_a_inc;
            end
            default: begin
`ifdef MYSYSTEM_OCIMEM_CPU_PORT_EN
              if (cpu_grant_rd)
                state <= CRD;
`endif
            end
          endcase
        end
        JRD: begin
          MonDReg       <= rd_q;
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // IDLE drains the slot every cycle, so it can always take a new strobe.
      if (new_act != ACT_NONE) begin
        if (idle || !pend_valid) begin
          pend_valid <= 1'b1;
          pend_act   <= new_act;
          pend_word  <= jdo[35:3];
        end else begin
          monitor_error <= 1'b1;
        end
      end else if (idle) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mysystem_cpu_debug_ocimem_ctrl.sv
// Scoreboard bench for mysystem_cpu_debug_ocimem_ctrl; CPU-port checks follow
// MYSYSTEM_OCIMEM_CPU_PORT_EN.
module tb_mysystem_cpu_debug_ocimem_ctrl;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_no_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_writedata;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  mysystem_cpu_debug_ocimem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_readdata            (cpu_readdata),
    .cpu_waitrequest         (cpu_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] jq_data[$];
  int          jq_cyc[$];
  logic [31:0] cq_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a result.
  initial begin
    logic        ready_prev;
    logic [31:0] e_data;
    int          e_cyc;
    ready_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (monitor_ready && !ready_prev) begin
        if (jq_data.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL jtag_unexpected: got result %h expected none", MonDReg);
        end else begin
          e_data = jq_data.pop_front();
          e_cyc  = jq_cyc.pop_front();
          check("jtag_data", MonDReg, e_data);
          check("jtag_latency", cyc, e_cyc);
        end
      end
      ready_prev = monitor_ready;
`ifdef MYSYSTEM_OCIMEM_CPU_PORT_EN
      if (cpu_read && !cpu_waitrequest) begin
        if (cq_data.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL cpu_unexpected: got readdata %h expected none", cpu_readdata);
        end else begin
          check("cpu_readdata", cpu_readdata, cq_data.pop_front());
        end
      end
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe_a(input logic rd, input logic [8:0] field);
    jdo = '0;
    jdo[35] = rd;
    jdo[25:17] = field;
    take_action_ocimem_a = 1'b1;
    step(1);
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic strobe_na();
    take_no_action_ocimem_a = 1'b1;
    step(1);
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [31:0] data);
    jdo = '0;
    jdo[34:3] = data;
    take_action_ocimem_b = 1'b1;
    step(1);
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30; i++) begin
      if (jq_data.size() == 0) break;
      step(1);
    end
    if (jq_data.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL jtag_timeout: got %0d outstanding expected 0", jq_data.size());
      jq_data.delete();
      jq_cyc.delete();
    end
    step(1);
  endtask

  task automatic jread_a(input logic [8:0] field, input logic [31:0] exp);
    jq_data.push_back(exp);
    jq_cyc.push_back(cyc + 3);
    strobe_a(1'b1, field);
    wait_drain();
  endtask

  task automatic jread_na(input logic [31:0] exp);
    jq_data.push_back(exp);
    jq_cyc.push_back(cyc + 3);
    strobe_na();
    wait_drain();
  endtask

`ifdef MYSYSTEM_OCIMEM_CPU_PORT_EN
  task automatic cpu_read_op(input logic [ADDR_W-1:0] addr, input logic [31:0] exp,
                             input int exp_lat);
    int start;
    int lat;
    cq_data.push_back(exp);
    cpu_address = addr;
    cpu_read = 1'b1;
    start = cyc;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_waitrequest) begin
        lat = cyc - start;
        break;
      end
      @(posedge clk);
      #1;
      take_action_ocimem_b = 1'b0;
    end
    check("cpu_rd_latency", lat, exp_lat);
    @(posedge clk);
    #1;
    cpu_read = 1'b0;
    if (lat < 0) cq_data.delete();
  endtask
`endif

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    cpu_address = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_writedata = '0;
    step(3);

    cpu_write = 1'b1;
    @(negedge clk);
    check("rst_mondreg", MonDReg, 32'h0);
    check("rst_ready", {31'b0, monitor_ready}, 32'h0);
    check("rst_error", {31'b0, monitor_error}, 32'h0);
    check("rst_readdata", cpu_readdata, 32'h0);
`ifdef MYSYSTEM_OCIMEM_CPU_PORT_EN
    check("rst_waitreq", {31'b0, cpu_waitrequest}, 32'h1);
`else
    check("rst_waitreq", {31'b0, cpu_waitrequest}, 32'h0);
`endif
    @(posedge clk);
    #1;
    cpu_write = 1'b0;
    reset = 1'b0;
    step(1);

    // Sequential writes from 0x10.
    strobe_a(1'b0, 9'h010);
    step(2);
    check("mon_a_load", {24'b0, dut.mon_a}, 32'h10);
    strobe_b(32'hA5A5_0001);
    step(1);
    strobe_b(32'hA5A5_0002);
    step(1);
    strobe_b(32'hA5A5_0003);
    step(2);
    check("mon_a_after_b", {24'b0, dut.mon_a}, 32'h13);

    jread_a(9'h010, 32'hA5A5_0001);
    jread_na(32'hA5A5_0002);
    jread_na(32'hA5A5_0003);

    // Illegal address field, then a legal one clears the error.
    strobe_a(1'b0, 9'h120);
    step(2);
    check("err_set", {31'b0, monitor_error}, 32'h1);
    check("err_mon_a_held", {24'b0, dut.mon_a}, 32'h12);
    strobe_a(1'b0, 9'h0FF);
    step(2);
    check("err_clear", {31'b0, monitor_error}, 32'h0);
    check("mon_a_ff", {24'b0, dut.mon_a}, 32'hFF);

    // Write at the top address wraps MonA.
    strobe_b(32'h1234_00FF);
    step(2);
    check("mon_a_wrap", {24'b0, dut.mon_a}, 32'h0);
    jread_a(9'h0FF, 32'h1234_00FF);

    // Read, one strobe pending, one strobe dropped.
    jq_data.push_back(32'hA5A5_0001);
    jq_cyc.push_back(cyc + 3);
    jq_data.push_back(32'hA5A5_0002);
    jq_cyc.push_back(cyc + 5);
    jdo = '0;
    jdo[35] = 1'b1;
    jdo[25:17] = 9'h010;
    take_action_ocimem_a = 1'b1;
    step(1);
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b1;
    step(2);
    take_no_action_ocimem_a = 1'b0;
    wait_drain();
    check("drop_error", {31'b0, monitor_error}, 32'h1);
    check("drop_mon_a", {24'b0, dut.mon_a}, 32'h11);

`ifdef MYSYSTEM_OCIMEM_CPU_PORT_EN
    strobe_a(1'b0, 9'h011);
    step(2);
    check("err_clear2", {31'b0, monitor_error}, 32'h0);
    // CPU read collides with a JTAG write to the same word.
    jdo = '0;
    jdo[34:3] = 32'hDEAD_0011;
    take_action_ocimem_b = 1'b1;
    cpu_read_op(8'h11, 32'hDEAD_0011, 3);
    step(1);
    cpu_address = 8'h20;
    cpu_writedata = 32'hCAFE_0020;
    cpu_write = 1'b1;
    @(negedge clk);
    check("cpu_wr_wait", {31'b0, cpu_waitrequest}, 32'h0);
    @(posedge clk);
    #1;
    cpu_write = 1'b0;
    step(1);
    cpu_read_op(8'h20, 32'hCAFE_0020, 1);
    step(1);
    jread_a(9'h020, 32'hCAFE_0020);
`else
    cpu_address = 8'h10;
    cpu_read = 1'b1;
    @(negedge clk);
    check("cpu_off_wait", {31'b0, cpu_waitrequest}, 32'h0);
    check("cpu_off_rdata", cpu_readdata, 32'h0);
    @(posedge clk);
    #1;
    cpu_read = 1'b0;
    cpu_writedata = 32'hFFFF_FFFF;
    cpu_write = 1'b1;
    step(1);
    cpu_write = 1'b0;
    step(1);
    jread_a(9'h010, 32'hA5A5_0001);
`endif

    // Reset while a JTAG read is in flight.
    jdo = '0;
    jdo[35] = 1'b1;
    jdo[25:17] = 9'h012;
    take_action_ocimem_a = 1'b1;
    step(1);
    take_action_ocimem_a = 1'b0;
    step(1);
    reset = 1'b1;
    #1;
    check("rst_mid_ready", {31'b0, monitor_ready}, 32'h0);
    check("rst_mid_mondreg", MonDReg, 32'h0);
    check("rst_mid_state", {30'b0, dut.state}, 32'h0);
    check("rst_mid_mon_a", {24'b0, dut.mon_a}, 32'h0);
    step(2);
    reset = 1'b0;
    step(2);
    jread_a(9'h012, 32'hA5A5_0003);
    jread_a(9'h0FF, 32'h1234_00FF);

    step(2);
    check("jq_empty", jq_data.size(), 32'h0);
    check("cq_empty", cq_data.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mysystem_cpu_debug_ocimem_ctrl.md
# mysystem_cpu_debug_ocimem_ctrl

System-clock debug-memory controller sitting directly downstream of the debug-slave wrapper. It consumes the `jdo` word and the `take_action_ocimem_*` strobes and services them against a single-port on-chip debug RAM. It also arbitrates CPU-side access to the same RAM. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the JTAG-side status path.

## Interface
- ADDR_W, 8: debug RAM word-address width; depth = 2^ADDR_W; legal range 4..9.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- jdo  in  38  JTAG data word from the sysclk stage, held stable from strobe to next strobe.
- take_action_ocimem_a  in  1  one-cycle strobe: load address, optional read.
- take_no_action_ocimem_a  in  1  one-cycle strobe: sequential read (address +1).
- take_action_ocimem_b  in  1  one-cycle strobe: write data, then address +1.
- cpu_address  in  ADDR_W  CPU word address.
- cpu_read / cpu_write  in  1  CPU requests (Avalon-MM, mutually exclusive).
- cpu_writedata  in  32  CPU write data.
- cpu_readdata  out  32  CPU read data.
- cpu_waitrequest  out  1  CPU stall.
- MonDReg  out  32  last JTAG read result.
- monitor_ready  out  1  JTAG read result valid.
- monitor_error  out  1  sticky JTAG access error.

## Operation
- Internal MonA register (ADDR_W bits), debug RAM of 2^ADDR_W x 32, one synchronous read port/write port shared.
- jdo decode: address field jdo[25:17] (9 bits); read flag jdo[35]; write data jdo[34:3].
- ocimem_a: MonA <= jdo[17+ADDR_W-1:17]; monitor_ready <= 0; if jdo[35], issue read of new MonA. If any field bit jdo[25:17+ADDR_W] is 1: monitor_error <= 1, MonA unchanged, no read.
- no_action_ocimem_a: MonA <= MonA+1 (wraps 2^ADDR_W-1 -> 0), monitor_ready <= 0, read new address.
- ocimem_b: RAM[MonA] <= jdo[34:3]; then MonA <= MonA+1 (wraps).
- monitor_error clears only on reset or on an ocimem_a whose address field is legal.
- FSM states: IDLE, JRD (JTAG read in flight), CRD (CPU read in flight). Writes complete from IDLE without leaving it.
- Priority each cycle: pending/arriving JTAG action > CPU request. CPU request loses -> cpu_waitrequest=1.
- One-entry pending slot: a strobe arriving while in JRD/CRD is latched and executed on return to IDLE; a second strobe while pending is full is dropped and sets monitor_error.
- CPU read: IDLE and no JTAG work -> CRD; readdata returned next cycle. CPU write: completes in the grant cycle.

## Timing
- Reset values: MonDReg=0, monitor_ready=0, monitor_error=0, cpu_readdata=0, MonA=0, pending empty, FSM IDLE. cpu_waitrequest = (cpu_read|cpu_write) & ~grant; high while reset asserted if requested.
- JTAG read: strobe sampled edge N; RAM read in cycle N+1 (JRD); MonDReg valid and monitor_ready=1 after edge N+2. monitor_ready stays 1 until next ocimem_a/no_action strobe.
- JTAG write: strobe at edge N; RAM updated and MonA+1 visible after edge N+1.
- CPU read granted in cycle N: waitrequest=1 in N, 0 in N+1 with cpu_readdata valid.
- CPU write granted in cycle N: waitrequest=0 in N; RAM updated at edge ending N.
- Reset mid-operation: in-flight read abandoned, pending dropped, RAM contents not cleared.

## Configuration
- MYSYSTEM_OCIMEM_CPU_PORT_EN defined: CPU port arbitrated as above.
- Undefined: CPU port inert; cpu_waitrequest=0, cpu_readdata=0, CPU writes ignored, CRD state absent; JTAG behaviour and latencies unchanged.

## Test plan
- ocimem_b x3 with MonA loaded 0x10, data 0xA5A5_0001..3 -> RAM[0x10..0x12] hold those values, MonA=0x13.
- ocimem_a addr 0x10 with jdo[35]=1 -> monitor_ready=1 two edges later, MonDReg=0xA5A5_0001; no_action strobe -> MonDReg=0xA5A5_0002.
- ADDR_W=8, ocimem_a with jdo[25]=1 -> monitor_error=1, MonA unchanged; later legal ocimem_a clears it.
- MonA=0xFF, ocimem_b -> write lands at 0xFF, MonA=0x00.
- cpu_read of 0x11 in same cycle as ocimem_b -> waitrequest held while JTAG write completes; CPU then reads updated value, waitrequest low exactly one cycle after grant.
- Reset asserted during JRD -> monitor_ready=0, MonDReg=0, FSM IDLE; RAM data previously written still read back correctly.
